// File: rtl/writeback_stage.sv
// Final pipeline stage: one-entry stage register, architectural regfile commit,
// wb forwarding record and retired-instruction counter. Optional WB_COMMIT_TRACE_EN adds sim trace/checks.
module writeback_stage #(
   parameter int          XLEN     = 32,
   parameter int          IID_W    = 16,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      mem_wb_valid,
   input  logic [31:0]               mem_wb_pc,
   input  logic [IID_W-1:0]          mem_wb_inst_id,
   input  logic                      mem_wb_rf_wen,
   input  logic [4:0]                mem_wb_wb_addr,
   input  logic [XLEN-1:0]           mem_wb_wdata,
   output logic                      wb_ready,
   output logic [31:0][XLEN-1:0]     regfile,
   output logic [XLEN+6:0]           dh_wb_fw,
   output logic                      wb_retire_valid,
   output logic [31:0]               wb_pc,
   output logic [IID_W-1:0]          wb_inst_id,
   output logic [63:0]               wb_instret
);

   logic                  r_valid;
   logic [31:0]           r_pc;
   logic [IID_W-1:0]      r_iid;
   logic                  r_rf_wen;
   logic [4:0]            r_addr;
   logic [XLEN-1:0]       r_wdata;
   logic [31:0][XLEN-1:0] r_rf;
   logic [63:0]           r_instret;
   logic                  w_fw_valid;

   // Stage never stalls; pc/id hold their last value while the stage is empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid  <= 1'b0;
         r_pc     <= RESET_PC;
         r_iid    <= '0;
         r_rf_wen <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
      end else begin
         r_valid <= mem_wb_valid;
         if (mem_wb_valid) begin
            r_pc     <= mem_wb_pc;
            r_iid    <= mem_wb_inst_id;
            r_rf_wen <= mem_wb_rf_wen;
            r_addr   <= mem_wb_wb_addr;
            r_wdata  <= mem_wb_wdata;
         end
      end
   end

   assign w_fw_valid = r_valid && r_rf_wen && (r_addr != 5'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rf <= '0;
      end else if (w_fw_valid) begin
         r_rf[r_addr] <= r_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instret <= '0;
      end else if (r_valid) begin
         r_instret <= r_instret + 64'd1;
      end
   end

   assign wb_ready        = 1'b1;
   assign regfile         = r_rf;
   assign dh_wb_fw        = w_fw_valid ? {2'b11, r_addr, r_wdata} : '0;
   assign wb_retire_valid = r_valid;
   assign wb_pc           = r_pc;
   assign wb_inst_id      = r_iid;
   assign wb_instret      = r_instret;

`ifdef WB_COMMIT_TRACE_EN
   always @(posedge clk) begin
      if (!rst) begin
         if (w_fw_valid)
            $display("data,wbstage.commit,h,%b", {r_pc, r_iid, r_addr, r_wdata});
         if (r_valid)
            $display("data,wbstage.retire,h,%h", r_iid);
         assert (!(mem_wb_rf_wen && !mem_wb_valid && (mem_wb_wb_addr != 5'd0)))
            else $error("wbstage protocol error: rf_wen without valid");
      end
   end
`else
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: driver pushes expected retire records,
// a monitor pops and compares whenever the stage presents a retiring instruction.
module tb_writeback_stage;

   logic              clk;
   logic              rst;
   logic              mem_wb_valid;
   logic [31:0]       mem_wb_pc;
   logic [15:0]       mem_wb_inst_id;
   logic              mem_wb_rf_wen;
   logic [4:0]        mem_wb_wb_addr;
   logic [31:0]       mem_wb_wdata;
   logic              wb_ready;
   logic [31:0][31:0] regfile;
   logic [38:0]       dh_wb_fw;
   logic              wb_retire_valid;
   logic [31:0]       wb_pc;
   logic [15:0]       wb_inst_id;
   logic [63:0]       wb_instret;

   typedef struct packed {
      logic [31:0] pc;
      logic [15:0] iid;
      logic [38:0] fw;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   writeback_stage dut (
      .clk             (clk),
      .rst             (rst),
      .mem_wb_valid    (mem_wb_valid),
      .mem_wb_pc       (mem_wb_pc),
      .mem_wb_inst_id  (mem_wb_inst_id),
      .mem_wb_rf_wen   (mem_wb_rf_wen),
      .mem_wb_wb_addr  (mem_wb_wb_addr),
      .mem_wb_wdata    (mem_wb_wdata),
      .wb_ready        (wb_ready),
      .regfile         (regfile),
      .dh_wb_fw        (dh_wb_fw),
      .wb_retire_valid (wb_retire_valid),
      .wb_pc           (wb_pc),
      .wb_inst_id      (wb_inst_id),
      .wb_instret      (wb_instret)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic issue(input logic [31:0] pc, input logic [15:0] iid, input logic wen,
                        input logic [4:0] addr, input logic [31:0] wd, input logic [38:0] exp_fw);
      exp_t e;
      @(negedge clk);
      mem_wb_valid   = 1'b1;
      mem_wb_pc      = pc;
      mem_wb_inst_id = iid;
      mem_wb_rf_wen  = wen;
      mem_wb_wb_addr = addr;
      mem_wb_wdata   = wd;
      e.pc  = pc;
      e.iid = iid;
      e.fw  = exp_fw;
      sb.push_back(e);
   endtask

   // Drop valid, then wait until just after the edge that commits the last issued write.
   task automatic idle_and_settle();
      @(negedge clk);
      mem_wb_valid  = 1'b0;
      mem_wb_rf_wen = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (wb_retire_valid) begin
            if (sb.size() == 0) begin
               n_checks++;
               $display("FAIL mon_unexpected_retire: got id %h expected no retire", wb_inst_id);
            end else begin
               e = sb.pop_front();
               chk("mon_pc",  {32'b0, wb_pc},      {32'b0, e.pc});
               chk("mon_iid", {48'b0, wb_inst_id}, {48'b0, e.iid});
               chk("mon_fw",  {25'b0, dh_wb_fw},   {25'b0, e.fw});
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin : driver
      rst = 1'b1;
      mem_wb_valid = 1'b0; mem_wb_pc = '0; mem_wb_inst_id = '0;
      mem_wb_rf_wen = 1'b0; mem_wb_wb_addr = '0; mem_wb_wdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_regfile_zero", {63'b0, |regfile}, 64'd0);
      chk("rst_fw_zero",      {25'b0, dh_wb_fw}, 64'd0);
      chk("rst_instret",      wb_instret, 64'd0);
      chk("rst_pc",           {32'b0, wb_pc}, 64'h0);
      chk("rst_retire_valid", {63'b0, wb_retire_valid}, 64'd0);
      chk("wb_ready",         {63'b0, wb_ready}, 64'd1);

      issue(32'h100, 16'd1, 1'b1, 5'd5, 32'hDEADBEEF, {1'b1, 1'b1, 5'd5, 32'hDEADBEEF});
      idle_and_settle();
      chk("single_rf5",     {32'b0, regfile[5]}, 64'hDEADBEEF);
      chk("single_instret", wb_instret, 64'd1);
      chk("single_fw_idle", {63'b0, dh_wb_fw[38]}, 64'd0);

      issue(32'h104, 16'd2, 1'b1, 5'd0, 32'h1234, 39'h0);
      idle_and_settle();
      chk("x0_rf0",     {32'b0, regfile[0]}, 64'd0);
      chk("x0_instret", wb_instret, 64'd2);

      issue(32'h108, 16'd3, 1'b1, 5'd7, 32'd1, {1'b1, 1'b1, 5'd7, 32'd1});
      issue(32'h10C, 16'd4, 1'b1, 5'd7, 32'd2, {1'b1, 1'b1, 5'd7, 32'd2});
      issue(32'h110, 16'd5, 1'b1, 5'd7, 32'd3, {1'b1, 1'b1, 5'd7, 32'd3});
      idle_and_settle();
      chk("b2b_rf7",       {32'b0, regfile[7]}, 64'd3);
      chk("b2b_instret",   wb_instret, 64'd5);
      chk("hold_pc",       {32'b0, wb_pc}, 64'h110);
      chk("hold_iid",      {48'b0, wb_inst_id}, 64'd5);
      chk("b2b_rf5_keep",  {32'b0, regfile[5]}, 64'hDEADBEEF);

      issue(32'h200, 16'd6, 1'b1, 5'd9, 32'hAA, {1'b1, 1'b1, 5'd9, 32'hAA});
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_fw_valid",     {63'b0, dh_wb_fw[38]}, 64'd0);
      chk("arst_retire_valid", {63'b0, wb_retire_valid}, 64'd0);
      chk("arst_instret",      wb_instret, 64'd0);
      chk("arst_pc",           {32'b0, wb_pc}, 64'h0);
      mem_wb_valid = 1'b0;
      mem_wb_rf_wen = 1'b0;
      @(posedge clk);
      #1;
      chk("arst_rf9",       {32'b0, regfile[9]}, 64'd0);
      chk("arst_rf_zero",   {63'b0, |regfile}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      @(negedge clk);
      force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.r_instret;
      issue(32'h300, 16'd7, 1'b0, 5'd3, 32'h55, 39'h0);
      idle_and_settle();
      chk("wrap_instret", wb_instret, 64'd0);
      chk("wrap_rf3",     {32'b0, regfile[3]}, 64'd0);
      chk("wrap_fw",      {25'b0, dh_wb_fw}, 64'd0);

      repeat (2) @(posedge clk);
      #2;
      chk("sb_drained", {32'b0, 32'(sb.size())}, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
